// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int          CNT_W         = 8;
    localparam logic [31:0] MMIO_BASE_DEF = 32'h4000_0000;

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_LD  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive denied loader cycles; at_limit_o forces a loader slot.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q != LIM)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU MEM stage vs UART bulk loader, with locked loader bursts.
// Define DMEM_ARB_STARVE_EN to add the loader starvation counter and forced slots.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          STARVE_LIMIT = 8,
    parameter int          BURST_MAX    = 16,
    parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic        ld_lock,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_gnt,
    output logic [31:0] ld_rdata,
    output logic        ld_err,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;

    logic     cpu_acc, at_limit, ld_sel, ld_beat, ld_rej, cpu_own;
    mem_req_t mreq;

    assign cpu_acc = cpu_re | cpu_we;
    // ld_sel is the loader winning a slot from S_CPU; inside S_LD every request is a beat.
    assign ld_sel  = (state_q == S_CPU) && ld_req && (!cpu_acc || at_limit);
    assign ld_beat = ld_sel || (state_q == S_LD && ld_req);
    assign ld_rej  = ld_beat && (ld_addr >= MMIO_BASE);
    assign cpu_own = (state_q == S_CPU) && !ld_sel && cpu_acc;

`ifdef DMEM_ARB_STARVE_EN
    logic st_clr, st_inc;
    assign st_clr = (state_q == S_CPU) && (!ld_req || ld_sel);
    assign st_inc = (state_q == S_CPU) && ld_req && !ld_sel;

    dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (st_clr),
        .inc_i      (st_inc),
        .at_limit_o (at_limit)
    );
`else
    assign at_limit = 1'b0;
`endif

    always_comb begin
        mreq      = '0;
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        ld_gnt    = 1'b0;
        ld_err    = 1'b0;
        ld_rdata  = '0;
        // Every output is held at zero while reset is asserted.
        if (reset) begin
            cpu_stall = cpu_acc && (state_q == S_LD || ld_sel);
            if (ld_beat) begin
                ld_gnt = 1'b1;
                ld_err = ld_rej;
                if (!ld_rej) begin
                    mreq.re    = !ld_we;
                    mreq.we    = ld_we;
                    mreq.addr  = ld_addr;
                    mreq.wdata = ld_wdata;
                    if (!ld_we) ld_rdata = mem_rdata;
                end
            end else if (cpu_own) begin
                mreq.re    = cpu_re;
                mreq.we    = cpu_we;
                mreq.addr  = cpu_addr;
                mreq.wdata = cpu_wdata;
                cpu_rdata  = mem_rdata;
            end
        end
    end

    assign mem_re    = mreq.re;
    assign mem_we    = mreq.we;
    assign mem_addr  = mreq.addr;
    assign mem_wdata = mreq.wdata;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            S_CPU: begin
                // The opening beat is beat 1; a one-beat burst never leaves S_CPU.
                if (ld_sel && ld_lock && BURST_MAX > 1) begin
                    state_d = S_LD;
                    burst_d = 8'd1;
                end
            end
            S_LD: begin
                if (ld_req) burst_d = burst_q + 8'd1;
                if (!ld_req || !ld_lock || (burst_q + 8'd1) == BURST_LAST) begin
                    state_d = S_CPU;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = S_CPU;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_CPU;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus protocol-respecting random traffic.
module tb_dmem_arbiter;

    localparam int          SL   = 8;
    localparam int          BM   = 4;
    localparam logic [31:0] MMIO = 32'h4000_0000;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re, cpu_we, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ld_req, ld_we, ld_lock, ld_gnt, ld_err;
    logic [31:0] ld_addr, ld_wdata, ld_rdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] tbmem [0:1023];

    always #5 clk = ~clk;

    assign mem_rdata = tbmem[mem_addr[11:2]];

    dmem_arbiter #(.STARVE_LIMIT(SL), .BURST_MAX(BM), .MMIO_BASE(MMIO)) dut (
        .clk(clk), .reset(reset),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port this cycle, from the ownership rules.
    bit          m_burst;
    int          m_starve, m_beats;
    bit          m_win;
    logic        e_gnt, e_err, e_stall, e_re, e_we;
    logic [31:0] e_addr, e_wdata, e_crd, e_lrd;

    task automatic model_eval();
        bit acc, rej, cpu_owns;
        {e_gnt, e_err, e_stall, e_re, e_we} = '0;
        e_addr = '0; e_wdata = '0; e_crd = '0; e_lrd = '0;
        m_win = 1'b0;
        if (reset) begin
            acc = cpu_re || cpu_we;
            rej = (ld_addr >= MMIO);
            if (m_burst) m_win = ld_req;
            else         m_win = ld_req && (!acc || (STARVE_EN && m_starve >= SL));
            cpu_owns = !m_burst && !m_win && acc;
            e_gnt   = m_win;
            e_err   = m_win && rej;
            e_stall = acc && (m_burst || m_win);
            if (m_win && !rej) begin
                e_re = !ld_we; e_we = ld_we; e_addr = ld_addr; e_wdata = ld_wdata;
                if (!ld_we) e_lrd = tbmem[ld_addr[11:2]];
            end else if (cpu_owns) begin
                e_re = cpu_re; e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
                e_crd = tbmem[cpu_addr[11:2]];
            end
        end
    endtask

    task automatic model_commit();
        if (!reset) begin
            m_burst = 1'b0; m_starve = 0; m_beats = 0;
        end else if (!m_burst) begin
            if (m_win) begin
                m_starve = 0;
                if (ld_lock && BM > 1) begin m_burst = 1'b1; m_beats = 1; end
            end else if (ld_req) begin
                m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            end else begin
                m_starve = 0;
            end
        end else begin
            if (ld_req) m_beats++;
            if (!ld_req || !ld_lock || m_beats >= BM) begin m_burst = 1'b0; m_beats = 0; end
        end
    endtask

    task automatic settle();
        #4;
        model_eval();
        chk("ld_gnt",    32'(ld_gnt),    32'(e_gnt));
        chk("ld_err",    32'(ld_err),    32'(e_err));
        chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        chk("mem_re",    32'(mem_re),    32'(e_re));
        chk("mem_we",    32'(mem_we),    32'(e_we));
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("ld_rdata",  ld_rdata,  e_lrd);
    endtask

    task automatic tick();
        logic        w;
        logic [31:0] a, d;
        w = mem_we; a = mem_addr; d = mem_wdata;
        @(posedge clk);
        model_commit();
        if (w) tbmem[a[11:2]] = d;
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return MMIO + (32'($urandom_range(0, 63)) << 2);
        return 32'($urandom_range(0, 1023)) << 2;
    endfunction

    initial begin
        int gcyc, grants, sent;
        logic [31:0] old;
        bit   last_gnt, last_stall;

        for (int i = 0; i < 1024; i++) tbmem[i] = $urandom;
        m_burst = 1'b0; m_starve = 0; m_beats = 0;

        // Reset held low with busy inputs: every output must be zero.
        reset = 1'b0;
        cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4; cpu_wdata = 32'h0;
        ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1; ld_addr = 32'h80; ld_wdata = 32'h55;
        repeat (2) begin
            settle();
            chk("rst_gnt",   32'(ld_gnt),    32'h0);
            chk("rst_stall", 32'(cpu_stall), 32'h0);
            chk("rst_we",    32'(mem_we),    32'h0);
            chk("rst_crd",   cpu_rdata,      32'h0);
            tick();
        end
        reset = 1'b1;
        cpu_re = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
        settle(); tick();

        // Idle CPU: loader write goes straight through.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h400; ld_wdata = 32'h61;
        settle();
        chk("idle_gnt",   32'(ld_gnt),    32'h1);
        chk("idle_we",    32'(mem_we),    32'h1);
        chk("idle_addr",  mem_addr,       32'h400);
        chk("idle_stall", 32'(cpu_stall), 32'h0);
        tick();
        ld_req = 1'b0;
        chk("idle_memwr", tbmem[10'h100], 32'h61);
        settle(); tick();

        // Continuous CPU access against a held loader read.
        cpu_re = 1'b1; cpu_addr = 32'h8;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10; ld_lock = 1'b0;
        gcyc = 0;
        for (int c = 1; c <= 20; c++) begin
            settle();
            if (gcyc != 0 && c == gcyc + 1) chk("starve_next_stall", 32'(cpu_stall), 32'h0);
            if (ld_gnt && gcyc == 0) begin
                gcyc = c;
                chk("starve_stall", 32'(cpu_stall), 32'h1);
            end
            tick();
            if (gcyc == c) ld_req = 1'b0;
        end
        chk("starve_cycle", 32'(gcyc), STARVE_EN ? 32'd9 : 32'd0);
        cpu_re = 1'b0; ld_req = 1'b0;
        settle(); tick();

        // Locked burst of 6 requested beats, CPU requesting from the second cycle.
        ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b1; ld_addr = 32'h200; ld_wdata = 32'hB0;
        grants = 0; sent = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (c >= 1 && c <= 3) chk("burst_stall", 32'(cpu_stall), 32'h1);
            if (c == 4) begin
                chk("burst_exit_gnt",   32'(ld_gnt),    32'h0);
                chk("burst_exit_stall", 32'(cpu_stall), 32'h0);
            end
            if (ld_gnt) begin
                grants++;
                sent++;
            end
            last_gnt = ld_gnt;
            tick();
            if (c == 0) begin cpu_re = 1'b1; cpu_addr = 32'h20; end
            if (last_gnt) begin
                ld_addr = ld_addr + 32'h4; ld_wdata = ld_wdata + 32'h1;
                if (sent == 6) ld_req = 1'b0;
            end
        end
        chk("burst_grants", 32'(grants), 32'd4);
        cpu_re = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
        settle(); tick();

        // Loader write into the MMIO window is rejected.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h4000_000C; ld_wdata = 32'hFF;
        settle();
        chk("mmio_gnt", 32'(ld_gnt), 32'h1);
        chk("mmio_err", 32'(ld_err), 32'h1);
        chk("mmio_we",  32'(mem_we), 32'h0);
        chk("mmio_re",  32'(mem_re), 32'h0);
        tick();
        ld_req = 1'b0;
        settle(); tick();

        // Reset dropped on beat 2 of a locked burst.
        ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b1; ld_addr = 32'h300; ld_wdata = 32'h11;
        settle();
        chk("rb_gnt1", 32'(ld_gnt), 32'h1);
        tick();
        ld_addr = 32'h304; ld_wdata = 32'h22; reset = 1'b0;
        old = tbmem[10'hC1];
        settle();
        chk("rb_gnt2", 32'(ld_gnt), 32'h0);
        chk("rb_we2",  32'(mem_we), 32'h0);
        tick();
        settle();
        chk("rb_hold_gnt", 32'(ld_gnt), 32'h0);
        chk("rb_hold_addr", mem_addr,   32'h0);
        tick();
        reset = 1'b1; ld_req = 1'b0; ld_lock = 1'b0;
        cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        settle();
        chk("rb_cpu_rdata", cpu_rdata, tbmem[0]);
        chk("rb_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("rb_nowrite", tbmem[10'hC1], old);
        tick();
        cpu_re = 1'b0;

        // Random traffic: CPU holds while stalled, loader holds until granted.
        last_gnt = 1'b1; last_stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) != 0);
            if (!last_stall) begin
                case ($urandom_range(0, 3))
                    0:       begin cpu_re = 1'b0; cpu_we = 1'b0; end
                    2:       begin cpu_re = 1'b0; cpu_we = 1'b1; end
                    default: begin cpu_re = 1'b1; cpu_we = 1'b0; end
                endcase
                cpu_addr = rnd_addr(); cpu_wdata = $urandom;
            end
            if (!ld_req || last_gnt) begin
                ld_req   = ($urandom_range(0, 2) != 0);
                ld_we    = 1'($urandom_range(0, 1));
                ld_lock  = 1'($urandom_range(0, 1));
                ld_addr  = rnd_addr();
                ld_wdata = $urandom;
            end
            settle();
            last_gnt = e_gnt; last_stall = e_stall;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single data-memory port between two requesters:
  - the MIPS pipeline MEM stage;
  - a UART-side bulk loader, which fills or dumps the string and pattern areas.
- CPU has priority. A loader starvation counter forces a loader slot and stalls the pipeline. A locked-burst mode lets the loader hold the port.
- Sits between the pipeline, the UART loader and the data-memory/MMIO block.

## Interface
Parameters:
- STARVE_LIMIT, 8: consecutive denied loader-request cycles before a forced loader slot (1..255).
- BURST_MAX, 16: max beats per locked loader burst (1..255).
- MMIO_BASE, 32'h4000_0000: loader accesses at or above this address are rejected.

Ports:
- clk  in  1  system clock
- reset  in  1  one clock; reset is synchronous and active-low
- cpu_re / cpu_we  in  1/1  CPU MemRead/MemWrite
- cpu_addr / cpu_wdata  in  32/32  CPU address, write data
- cpu_rdata  out  32  read data to CPU
- cpu_stall  out  1  CPU must hold its request this cycle
- ld_req  in  1  loader request
- ld_we  in  1  1 = write, 0 = read
- ld_lock  in  1  hold the port for a burst
- ld_addr / ld_wdata  in  32/32  loader address, write data
- ld_gnt  out  1  loader access performed this cycle
- ld_rdata  out  32  loader read data, valid when ld_gnt & !ld_we
- ld_err  out  1  loader access rejected (MMIO range)
- mem_re / mem_we  out  1/1  to data memory
- mem_addr / mem_wdata  out  32/32  to data memory
- mem_rdata  in  32  combinational read data from memory

## Operation
- States are S_CPU (reset state) and S_LD.
- Registers: starve_cnt (8b, saturates at STARVE_LIMIT), burst_cnt (8b).
- cpu_acc = cpu_re | cpu_we.
- **S_CPU, loader selected:** ld_req & (!cpu_acc | starve_cnt == STARVE_LIMIT).
  - Loader drives mem_*, ld_gnt = 1, starve_cnt ← 0.
  - cpu_stall = cpu_acc.
  - If ld_lock: go to S_LD with burst_cnt ← 1.
- **S_CPU, otherwise:**
  - CPU drives mem_* (passthrough). cpu_stall = 0.
  - If ld_req is denied: starve_cnt increments (saturating).
  - If ld_req = 0: starve_cnt ← 0.
- **S_LD:**
  - Loader owns the port. cpu_stall = cpu_acc. ld_gnt = ld_req. Each granted beat increments burst_cnt.
  - Exit to S_CPU after the beat on which any of these holds:
    - !ld_req;
    - !ld_lock;
    - the beat is the BURST_MAX-th.
  - On exit, burst_cnt ← 0.
- **MMIO reject:** a granted loader beat with ld_addr ≥ MMIO_BASE:
  - ld_gnt = 1, ld_err = 1;
  - mem_re = mem_we = 0;
  - still consumes the slot and counts as a burst beat.
- **Read data routing:**
  - cpu_rdata = mem_rdata when the CPU owns the cycle, else 0.
  - ld_rdata = mem_rdata on a granted, non-rejected read, else 0.
- Unowned cycles: mem_* = 0.

## Timing
- Grant, stall and mem_* are combinational from the current state, counters and inputs. There is no added latency.
- Memory writes commit at the next posedge.
- The loader must hold ld_req/ld_addr/ld_wdata stable until it sees ld_gnt. It may change them on the cycle after ld_gnt.
- A stalled CPU holds cpu_* unchanged (pipeline freeze). The arbiter does not buffer them.
- Simultaneous loader request and starve_cnt == STARVE_LIMIT with CPU access: the loader wins, the CPU is stalled exactly one cycle, and the CPU wins the next cycle unless in S_LD.
- Reset low at a clock edge:
  - next state S_CPU; counters 0;
  - while reset is low, all outputs are 0;
  - an in-flight burst is abandoned with no partial write beyond beats already granted.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation counter and forced slots present, as above.
- Undefined:
  - strict CPU priority; the loader is granted only when !cpu_acc;
  - in S_CPU, cpu_stall is never asserted;
  - S_LD bursts still stall the CPU.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (S_CPU, S_LD);
  - MMIO_BASE default;
  - counter width constant CNT_W = 8.
- One sub-module, dmem_arb_starve_ctr: saturating counter with clear/increment and an at_limit output. It is the only instance under the macro.

## Test plan
- **Idle CPU:** ld_req write 0x61 to 0x400 → ld_gnt same cycle, mem_we = 1, mem_addr = 0x400, no stall.
- **Continuous CPU access, STARVE_LIMIT = 8:**
  - macro on: ld_req held → ld_gnt on the 9th cycle with cpu_stall = 1 for that cycle only;
  - macro off: never granted.
- **Locked burst, BURST_MAX = 4, ld_lock held, 6 beats requested:**
  - 4 grants, then a return to S_CPU;
  - cpu_stall = 1 throughout if the CPU is requesting.
- **Loader write to 0x4000_000C** → ld_gnt = 1, ld_err = 1, mem_we = 0, LEDs unchanged.
- **Reset low mid-burst (beat 2)** → next cycle: S_CPU, all outputs 0. After release, the CPU read of 0x0 returns memory data with no stall.
